// File: rtl/bus_mem_pkg.sv
// bus_mem_pkg: shared types and defaults for the stalling bus memory responder.
package bus_mem_pkg;
   localparam int ADDR_WORDS_LOG2_DEF = 12;
   typedef enum logic {IDLE, STALL} bus_mem_state_t;
   typedef struct packed {
      logic [31:0] addr;
      logic        read;
      logic        write;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_req_t;
endpackage

// File: rtl/bus_stall_ctrl.sv
// bus_stall_ctrl: waitrequest stall FSM, stall counter and initiator protocol checker.
module bus_stall_ctrl
   import bus_mem_pkg::*;
#(
   parameter int unsigned NUM_STALLS = 0
) (
   input  logic     clk,
   input  logic     reset,
   input  bus_req_t req_i,
   output logic     waitrequest_o,
   output logic     done_o,
   output logic     protocol_err_o
);
   localparam logic [7:0] NS = 8'(NUM_STALLS);
   bus_mem_state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   bus_req_t hold_q, hold_d;
   logic err_q, err_d, req, stall, viol;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
      end
   end
   // a transfer is held off while counting; reset forces it released and idle
   always_comb begin
      req     = req_i.read | req_i.write;
      stall   = ~reset & req & (cnt_q != NS);
      viol    = req & ((req_i.read & req_i.write) | (req_i.addr[1:0] != 2'b00) |
                       (state_q == STALL && req_i != hold_q));
      state_d = stall ? STALL : IDLE;
      cnt_d   = stall ? cnt_q + 8'd1 : 8'd0;
      hold_d  = stall ? req_i : hold_q;
      err_d   = err_q | viol;
   end
   assign waitrequest_o  = stall;
   assign done_o         = ~reset & req & ~stall;
   assign protocol_err_o = err_q;
endmodule

// File: rtl/bus_stall_memory.sv
// bus_stall_memory: Avalon-MM style word memory with programmable waitrequest stalls.
module bus_stall_memory
  import bus_mem_pkg::*;
#(
  parameter string       RAM_INIT_FILE   = "",
  parameter int unsigned NUM_STALLS      = 0,
  parameter int          ADDR_WORDS_LOG2 = ADDR_WORDS_LOG2_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        protocol_err
);
  logic [31:0] mem_q [2**ADDR_WORDS_LOG2];
  logic [ADDR_WORDS_LOG2-1:0] idx;
  logic done;
  bus_req_t req;
  assign req = '{addr: address, read: read, write: write, be: byteenable, wdata: writedata};
  assign idx = address[ADDR_WORDS_LOG2+1:2];
  bus_stall_ctrl #(.NUM_STALLS(NUM_STALLS)) u_ctrl (
    .clk            (clk),
    .reset          (reset),
    .req_i          (req),
    .waitrequest_o  (waitrequest),
    .done_o         (done),
    .protocol_err_o (protocol_err)
  );
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (done && write && byteenable[b]) mem_q[idx][8*b +: 8] <= writedata[8*b +: 8];
  end
  assign readdata = (done & read & ~write) ? mem_q[idx] : 32'h0;
endmodule

// File: tb/tb_bus_stall_memory.sv
// tb_bus_stall_memory: directed table, corner sequences and random traffic over four stall settings.
module tb_bus_stall_memory;
   localparam int NS [4] = '{0, 2, 3, 4};
   logic clk = 1'b0;
   logic rs [4], rd_a [4], wr_a [4], wq [4], eq [4];
   logic [31:0] ad_a [4], wd_a [4], rq [4];
   logic [3:0] be_a [4];
   logic [31:0] mdl [4][4096];
   bit merr [4];
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 4; g++) begin : g_dut
      bus_stall_memory #(.NUM_STALLS(NS[g])) u_dut (
         .clk          (clk),
         .reset        (rs[g]),
         .address      (ad_a[g]),
         .read         (rd_a[g]),
         .write        (wr_a[g]),
         .writedata    (wd_a[g]),
         .byteenable   (be_a[g]),
         .waitrequest  (wq[g]),
         .readdata     (rq[g]),
         .protocol_err (eq[g])
      );
   end
   typedef struct {
      int k; bit r; bit w; logic [31:0] a; logic [31:0] d; logic [3:0] be;
      logic [31:0] erd; bit eerr;
   } vec_t;
   vec_t tbl [11];
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask
   task automatic idle(input int k);
      rd_a[k] = 1'b0;
      wr_a[k] = 1'b0;
   endtask
   // one complete transfer; inputs stay asserted afterwards so a following call is back-to-back
   task automatic xfer(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] exp_rd, input bit exp_err);
      int st = 0;
      rd_a[k] = r; wr_a[k] = w; ad_a[k] = a; wd_a[k] = d; be_a[k] = be;
      #1;
      while (wq[k] && st < 300) begin
         st++;
         @(negedge clk);
         #1;
      end
      chk($sformatf("stalls[%0d]", k), st, NS[k]);
      chk($sformatf("rdata[%0d]", k), rq[k], exp_rd);
      @(negedge clk);
      if (w) for (int b = 0; b < 4; b++) if (be[b]) mdl[k][a[13:2]][8*b +: 8] = d[8*b +: 8];
      merr[k] = merr[k] | (r & w) | (a[1:0] != 2'b00);
      #1 chk($sformatf("err[%0d]", k), {31'b0, eq[k]}, {31'b0, exp_err});
   endtask
   initial begin
      for (int k = 0; k < 4; k++) begin
         rs[k] = 1'b1; rd_a[k] = 1'b1; wr_a[k] = 1'b0;
         ad_a[k] = 32'h0; wd_a[k] = 32'h0; be_a[k] = 4'hf; merr[k] = 1'b0;
         for (int i = 0; i < 4096; i++) mdl[k][i] = 32'h0;
      end
      tbl[0]  = '{0, 0, 1, 32'h0000_0000, 32'h2402_0005, 4'hf, 32'h0, 1'b0};
      tbl[1]  = '{0, 1, 0, 32'hBFC0_0000, 32'h0,         4'hf, 32'h2402_0005, 1'b0};
      tbl[2]  = '{2, 0, 1, 32'h0000_0010, 32'hAABB_CCDD, 4'hf, 32'h0, 1'b0};
      tbl[3]  = '{2, 1, 0, 32'h0000_0010, 32'h0,         4'hf, 32'hAABB_CCDD, 1'b0};
      tbl[4]  = '{2, 0, 1, 32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0, 1'b0};
      tbl[5]  = '{2, 1, 0, 32'h0000_0010, 32'h0,         4'hf, 32'hAA22_CC44, 1'b0};
      tbl[6]  = '{2, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h0, 32'h0, 1'b0};
      tbl[7]  = '{2, 1, 0, 32'h0000_0010, 32'h0,         4'hf, 32'hAA22_CC44, 1'b0};
      tbl[8]  = '{0, 1, 1, 32'h0000_0010, 32'h5566_7788, 4'hf, 32'h0, 1'b1};
      tbl[9]  = '{0, 1, 0, 32'h0000_0013, 32'h0,         4'hf, 32'h5566_7788, 1'b1};
      tbl[10] = '{0, 1, 0, 32'h0000_0010, 32'h0,         4'hf, 32'h5566_7788, 1'b1};
      repeat (2) @(negedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_wait[%0d]", k), {31'b0, wq[k]}, 32'h0);
         chk($sformatf("rst_rdata[%0d]", k), rq[k], 32'h0);
         chk($sformatf("rst_err[%0d]", k), {31'b0, eq[k]}, 32'h0);
         idle(k);
         rs[k] = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         xfer(tbl[i].k, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].erd, tbl[i].eerr);
         if (i == 10 || tbl[i+1].k != tbl[i].k) idle(tbl[i].k);
      end
      // address changed mid-stall, then a request dropped mid-stall (2 stalls)
      xfer(1, 0, 1, 32'h40, 32'h0BAD_F00D, 4'hf, 32'h0, 1'b0);
      xfer(1, 0, 1, 32'h44, 32'h4444_4444, 4'hf, 32'h0, 1'b0);
      idle(1);
      @(negedge clk);
      rd_a[1] = 1'b1; ad_a[1] = 32'h40;
      #1 chk("hold_wait0", {31'b0, wq[1]}, 32'h1);
      @(negedge clk);
      ad_a[1] = 32'h44;
      #1 chk("hold_wait1", {31'b0, wq[1]}, 32'h1);
      @(negedge clk);
      #1 chk("hold_wait2", {31'b0, wq[1]}, 32'h0);
      chk("hold_rdata", rq[1], 32'h4444_4444);
      @(negedge clk);
      #1 chk("hold_err", {31'b0, eq[1]}, 32'h1);
      idle(1);
      merr[1] = 1'b1;
      @(negedge clk);
      wr_a[1] = 1'b1; ad_a[1] = 32'h40; wd_a[1] = 32'hFFFF_FFFF; be_a[1] = 4'hf;
      #1 chk("drop_wait", {31'b0, wq[1]}, 32'h1);
      @(negedge clk);
      idle(1);
      @(negedge clk);
      xfer(1, 1, 0, 32'h40, 32'h0, 4'hf, 32'h0BAD_F00D, 1'b1);
      idle(1);
      // reset asserted mid-stall (4 stalls)
      xfer(3, 0, 1, 32'h20, 32'h1234_5678, 4'hf, 32'h0, 1'b0);
      xfer(3, 1, 0, 32'h21, 32'h0, 4'hf, 32'h1234_5678, 1'b1);
      idle(3);
      @(negedge clk);
      wr_a[3] = 1'b1; ad_a[3] = 32'h20; wd_a[3] = 32'hFFFF_FFFF; be_a[3] = 4'hf;
      #1 chk("rst_mid_wait0", {31'b0, wq[3]}, 32'h1);
      @(negedge clk);
      #1 chk("rst_mid_wait1", {31'b0, wq[3]}, 32'h1);
      @(negedge clk);
      rs[3] = 1'b1;
      #1 chk("rst_mid_wait", {31'b0, wq[3]}, 32'h0);
      chk("rst_mid_err", {31'b0, eq[3]}, 32'h0);
      chk("rst_mid_rdata", rq[3], 32'h0);
      @(negedge clk);
      idle(3);
      rs[3] = 1'b0;
      merr[3] = 1'b0;
      @(negedge clk);
      xfer(3, 1, 0, 32'h20, 32'h0, 4'hf, 32'h1234_5678, 1'b0);
      idle(3);
      // random traffic against the word-array model
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 64; i++)
            xfer(k, 0, 1, ($urandom & 32'hFFFF_C000) | (i << 2), $urandom, 4'hf, 32'h0, merr[k]);
         for (int i = 0; i < 60; i++) begin
            int op = $urandom_range(0, 15);
            bit r = (op == 0) || op[0];
            bit w = (op == 0) || !op[0];
            logic [31:0] a = $urandom & 32'hFFFF_C0FC;
            logic [31:0] exp_rd;
            bit e;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            exp_rd = (r && !w) ? mdl[k][a[13:2]] : 32'h0;
            e = merr[k] | (r & w) | (a[1:0] != 2'b00);
            xfer(k, r, w, a, $urandom, 4'($urandom), exp_rd, e);
            if ($urandom_range(0, 1) == 0) begin
               idle(k);
               @(negedge clk);
            end
         end
         idle(k);
         @(negedge clk);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
